// File: rtl/pipe_ctrl_pkg.sv
// Shared types, defaults and output encodings for the pipeline stall controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        DRAIN    = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam int unsigned DRAIN_CYCLES_D = 4;
    localparam int unsigned TIMEOUT_D      = 255;
    localparam int unsigned CNT_WIDTH_D    = 16;
    localparam int unsigned DRAIN_W        = 4;
    localparam int unsigned WAIT_W         = 16;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_bubble;
        logic idex_bubble;
    } ctrl_t;

    // Pipeline fills with bubbles while the front end is held.
    localparam ctrl_t CTRL_DRAIN = '{pc_en: 1'b0, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
                                     memwb_en: 1'b1, ifid_bubble: 1'b1, idex_bubble: 1'b1};

    // Fixed-priority hazard resolution: memory stall, branch flush, load-use stall, free run.
    function automatic ctrl_t run_ctrl(input logic mem_busy, input logic branch_taken,
                                       input logic load_use);
        ctrl_t c;
        c = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
              memwb_en: 1'b1, ifid_bubble: 1'b0, idex_bubble: 1'b0};
        if (mem_busy) begin
            c = '0;
        end else if (branch_taken) begin
            c.ifid_bubble = 1'b1;
            c.idex_bubble = 1'b1;
        end else if (load_use) begin
            c.pc_en       = 1'b0;
            c.ifid_en     = 1'b0;
            c.idex_bubble = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and synchronous active-high reset.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear wins over increment; the count sticks at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: drains after reset, resolves hazards, tracks stalls and memory timeouts.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_D,
    parameter int unsigned TIMEOUT      = TIMEOUT_D,
    parameter int unsigned CNT_WIDTH    = CNT_WIDTH_D
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_busy,
    input  logic                 branch_taken,
    input  logic                 load_use,
    input  logic                 stall_clr,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_en,
    output logic                 exmem_en,
    output logic                 memwb_en,
    output logic                 ifid_bubble,
    output logic                 idex_bubble,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic                 mem_timeout
);

    state_e              state_q;
    state_e              state_d;
    logic [DRAIN_W-1:0]  drain_q;
    logic [DRAIN_W-1:0]  drain_d;
    logic                mem_timeout_q;
    logic                mem_timeout_d;
    ctrl_t               ctrl_c;
    logic                wait_inc;
    logic                wait_clr;
    logic                stall_inc;
    logic                timeout_hit;
    logic [WAIT_W-1:0]   wait_cnt;

    // Next-state and hazard outputs; reset forces drain outputs combinationally.
    always_comb begin
        state_d  = state_q;
        drain_d  = '0;
        ctrl_c   = CTRL_DRAIN;
        wait_inc = 1'b0;
        wait_clr = 1'b0;
        if (!reset) begin
            unique case (state_q)
                DRAIN: begin
                    if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        state_d = RUN;
                    end else begin
                        drain_d = drain_q + DRAIN_W'(1);
                    end
                end
                RUN: begin
                    ctrl_c = run_ctrl(mem_busy, branch_taken, load_use);
                    if (mem_busy) begin
                        state_d = MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    ctrl_c = run_ctrl(mem_busy, branch_taken, load_use);
                    if (mem_busy) begin
                        wait_inc = 1'b1;
                    end else begin
                        wait_clr = 1'b1;
                        state_d  = RUN;
                    end
                end
                default: state_d = DRAIN;
            endcase
        end
    end

    // Timeout flags on the edge where the wait count reaches TIMEOUT; clear wins.
    always_comb begin
        stall_inc     = (state_q != DRAIN) && !ctrl_c.pc_en;
        timeout_hit   = wait_inc && (wait_cnt >= WAIT_W'(TIMEOUT - 1));
        mem_timeout_d = stall_clr ? 1'b0 : (mem_timeout_q | timeout_hit);
    end

    // State, drain counter and sticky timeout registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= DRAIN;
            drain_q       <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_q       <= drain_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (stall_inc),
        .clr_i   (stall_clr),
        .count_o (stall_count)
    );

    sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (wait_inc),
        .clr_i   (wait_clr),
        .count_o (wait_cnt)
    );

    assign pc_en       = ctrl_c.pc_en;
    assign ifid_en     = ctrl_c.ifid_en;
    assign idex_en     = ctrl_c.idex_en;
    assign exmem_en    = ctrl_c.exmem_en;
    assign memwb_en    = ctrl_c.memwb_en;
    assign ifid_bubble = ctrl_c.ifid_bubble;
    assign idex_bubble = ctrl_c.idex_bubble;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl with a small TIMEOUT and narrow stall counter.
module tb_pipe_stall_ctrl;

    localparam int DC = 4;
    localparam int TO = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_busy = 1'b0;
    logic          branch_taken = 1'b0;
    logic          load_use = 1'b0;
    logic          stall_clr = 1'b0;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_bubble, idex_bubble;
    logic [CW-1:0] stall_count;
    logic          mem_timeout;

    pipe_stall_ctrl #(.DRAIN_CYCLES(DC), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_busy     (mem_busy),
        .branch_taken (branch_taken),
        .load_use     (load_use),
        .stall_clr    (stall_clr),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_bubble  (ifid_bubble),
        .idex_bubble  (idex_bubble),
        .stall_count  (stall_count),
        .mem_timeout  (mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]    ctl;
        logic [CW-1:0] cnt;
        logic          to;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: 0 drain, 1 run, 2 memory wait.
    int   m_state = 0;
    int   m_drain = 0;
    int   m_wait  = 0;
    int   m_cnt   = 0;
    bit   m_to    = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {pc, ifid, idex, exmem, memwb, ifid_bubble, idex_bubble}.
    function automatic logic [6:0] model_ctl(input bit rst, input bit busy, input bit br, input bit lu);
        if (rst || m_state == 0) return 7'b0111111;
        if (busy)                return 7'b0000000;
        if (br)                  return 7'b1111111;
        if (lu)                  return 7'b0011101;
        return 7'b1111100;
    endfunction

    task automatic step(input bit rst, input bit busy, input bit br, input bit lu, input bit clr);
        exp_t       e;
        exp_t       got_e;
        logic [6:0] c;
        int         old_state;
        bit         hit;
        @(posedge clk);
        #1;
        reset        = rst;
        mem_busy     = busy;
        branch_taken = br;
        load_use     = lu;
        stall_clr    = clr;
        c = model_ctl(rst, busy, br, lu);
        e.ctl = c;
        e.cnt = CW'(m_cnt);
        e.to  = m_to;
        sb_q.push_back(e);
        @(negedge clk);
        got_e = sb_q.pop_front();
        check("ctl", 16'({pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_bubble, idex_bubble}),
              16'(got_e.ctl));
        check("stall_count", 16'(stall_count), 16'(got_e.cnt));
        check("mem_timeout", 16'(mem_timeout), 16'(got_e.to));
        // Advance the model across the coming rising edge.
        if (rst) begin
            m_state = 0; m_drain = 0; m_wait = 0; m_cnt = 0; m_to = 1'b0;
        end else begin
            old_state = m_state;
            hit = 1'b0;
            case (m_state)
                0: if (m_drain == DC - 1) begin m_state = 1; m_drain = 0; end
                   else m_drain++;
                1: if (busy) m_state = 2;
                default: begin
                    if (busy) begin
                        if (m_wait < 65535) m_wait++;
                        if (m_wait >= TO) hit = 1'b1;
                    end else begin
                        m_wait = 0;
                        m_state = 1;
                    end
                end
            endcase
            if (clr) m_cnt = 0;
            else if (old_state != 0 && !c[6] && m_cnt < (1 << CW) - 1) m_cnt++;
            if (clr) m_to = 1'b0;
            else if (hit) m_to = 1'b1;
        end
    endtask

    initial begin
        // Reset two cycles, then a four-cycle drain, then free run.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < DC; i++) begin
            step(0, 0, 0, 0, 0);
            check("drain_pc_en", 16'(pc_en), 16'd0);
        end
        step(0, 0, 0, 0, 0);
        check("run_pc_en", 16'(pc_en), 16'd1);
        check("run_cnt0", 16'(stall_count), 16'd0);

        // Single load-use bubble.
        step(0, 0, 0, 1, 0);
        check("lu_ifid_en", 16'(ifid_en), 16'd0);
        step(0, 0, 0, 0, 0);
        check("lu_cnt", 16'(stall_count), 16'd1);
        step(0, 0, 0, 0, 1);

        // All three hazards at once, three more busy cycles, release with a branch.
        step(0, 1, 1, 1, 0);
        check("prio_bubble", 16'(ifid_bubble), 16'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("prio_cnt", 16'(stall_count), 16'd4);
        check("prio_br_bubble", 16'(idex_bubble), 16'd1);
        step(0, 0, 0, 0, 1);

        // Memory timeout after TIMEOUT wait cycles, sticky until cleared.
        for (int i = 1; i <= 12; i++) begin
            step(0, 1, 0, 0, 0);
            check("to_dir", 16'(mem_timeout), (i >= 10) ? 16'd1 : 16'd0);
        end
        step(0, 0, 0, 0, 0);
        check("to_sticky", 16'(mem_timeout), 16'd1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        check("to_clr", 16'(mem_timeout), 16'd0);
        check("cnt_clr", 16'(stall_count), 16'd0);

        // Stall counter saturation.
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        check("sat_cnt", 16'(stall_count), 16'd15);

        // Reset during the third busy cycle.
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < DC; i++) begin
            step(0, 0, 0, 0, 0);
            check("rst_drain_bubble", 16'(ifid_bubble), 16'd1);
        end
        check("rst_cnt", 16'(stall_count), 16'd0);
        step(0, 0, 0, 0, 0);
        check("rst_run_pc_en", 16'(pc_en), 16'd1);

        // Random traffic with occasional resets and clears.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 4));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 4: post-reset bubble-fill cycles, range 1..15.
REQ-002 SHALL have parameter TIMEOUT, default 255: mem_busy cycles before timeout, range 1..65535.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: stall counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-006 SHALL have port mem_busy, input, 1 bit: data memory cannot complete this cycle.
REQ-007 SHALL have port branch_taken, input, 1 bit: EX resolved a taken branch this cycle.
REQ-008 SHALL have port load_use, input, 1 bit: ID instruction needs the EX load result.
REQ-009 SHALL have port stall_clr, input, 1 bit: clears stall_count and mem_timeout.
REQ-010 SHALL have ports pc_en, ifid_en, idex_en, exmem_en, memwb_en, output, 1 bit each: pipeline register enables.
REQ-011 SHALL have ports ifid_bubble, idex_bubble, output, 1 bit each: force NOP into that stage's register.
REQ-012 SHALL have port stall_count, output, CNT_WIDTH bits: saturating count of cycles with pc_en=0 in RUN or MEM_WAIT.
REQ-013 SHALL have port mem_timeout, output, 1 bit: sticky error flag.

Function
REQ-014 SHALL implement states DRAIN, RUN and MEM_WAIT.
REQ-015 DRAIN outputs SHALL be: pc_en=0; ifid_en, idex_en, exmem_en, memwb_en=1; ifid_bubble, idex_bubble=1.
REQ-016 DRAIN SHALL go to RUN after exactly DRAIN_CYCLES cycles, tracked by a 4-bit drain counter; inputs are ignored in DRAIN.
REQ-017 RUN SHALL select outputs by fixed priority: mem_busy, then branch_taken, then load_use, then none.
REQ-018 RUN with mem_busy=1 SHALL drive all enables 0 and both bubbles 0, and go to MEM_WAIT next cycle.
REQ-019 RUN with branch_taken=1 (mem_busy=0) SHALL drive all enables 1 and ifid_bubble=idex_bubble=1, then stay in RUN; a coincident load_use is discarded.
REQ-020 RUN with load_use=1 only SHALL drive pc_en=0, ifid_en=0, idex_bubble=1 and all other enables 1; the stall lasts as long as load_use holds.
REQ-021 RUN with no event SHALL drive all enables 1 and both bubbles 0.
REQ-022 MEM_WAIT with mem_busy=1 SHALL drive all enables 0 and increment a wait counter.
REQ-023 MEM_WAIT with mem_busy=0 SHALL apply RUN outputs (REQ-019 to REQ-021) for that cycle, clear the wait counter and return to RUN.
REQ-024 When the wait counter reaches TIMEOUT, mem_timeout SHALL set the next cycle, hold until stall_clr or reset, and the stall SHALL continue.
REQ-025 stall_count SHALL increment by 1 in each RUN or MEM_WAIT cycle with pc_en=0, and saturate at all-ones with no wrap.
REQ-026 stall_clr SHALL zero stall_count and mem_timeout the next cycle and take priority over a same-cycle increment.
REQ-027 All outputs SHALL be combinational from the state register and current inputs; there are no other combinational input-to-output paths.

Reset
REQ-028 reset=1 at a clock edge SHALL set state=DRAIN and zero the drain counter, wait counter, stall_count and mem_timeout.
REQ-029 While reset=1, outputs SHALL equal DRAIN outputs.
REQ-030 reset SHALL override any in-progress MEM_WAIT or stall, and the full DRAIN_CYCLES sequence SHALL restart after reset deasserts.

Structure
REQ-031 Package pipe_ctrl_pkg SHALL hold the state enum (DRAIN, RUN, MEM_WAIT) and the default constants DRAIN_CYCLES_D, TIMEOUT_D and CNT_WIDTH_D.
REQ-032 The block SHALL use one sub-module, sat_counter (parameterised width, inc, clr, synchronous reset), instantiated for stall_count and for the wait counter.

Verification
REQ-033 Reset then idle: hold reset for 2 cycles, then release -> pc_en=0 and bubbles=1 for exactly 4 cycles, then all enables=1, bubbles=0, stall_count=0.
REQ-034 Load-use: pulse load_use for 1 cycle in RUN -> that cycle pc_en=0, ifid_en=0, idex_bubble=1; next cycle all enables=1; stall_count=1.
REQ-035 Priority: mem_busy=1, branch_taken=1 and load_use=1 in the same cycle -> all enables=0, no bubble, MEM_WAIT next; then hold 3 cycles, drop mem_busy with branch_taken=1 -> that cycle bubbles=1, enables=1, and stall_count=4.
REQ-036 Timeout with TIMEOUT=8: hold mem_busy 12 cycles -> mem_timeout=1 from the 10th cycle and stays 1 after mem_busy drops; stall_clr -> mem_timeout=0 and stall_count=0 next cycle.
REQ-037 Saturation with CNT_WIDTH=4: hold load_use 20 cycles -> stall_count stops at 15.
REQ-038 Reset mid-MEM_WAIT: reset during the 3rd busy cycle -> next cycle DRAIN outputs, all counters 0, and a 4-cycle drain after release.
